// File: rtl/avalon_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_cmd_pkg
// Description : Op/status codes, FSM encoding and register map shared by the
//               Avalon command master and its register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_cmd_pkg;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_POLL     = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_BADOP    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_RDWAIT = 3'd2,
        S_GAP    = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    localparam logic [5:0]  REG_CTRL    = 6'h00;
    localparam logic [5:0]  REG_COUNT   = 6'h04;
    localparam logic [5:0]  REG_ZERO    = 6'h08;
    localparam logic [5:0]  REG_VERSION = 6'h0C;
    localparam logic [31:0] SYS_VERSION = 32'd20;

endpackage
`default_nettype wire

// File: rtl/avalon_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : avalon_cmd_master
// Description : Turns host WRITE/READ/POLL commands into single Avalon-MM bus
//               cycles and returns one response per command. POLL support is
//               built only when AVALON_CMD_MASTER_POLL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_cmd_master #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_MAX     = 1024,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [DATA_WIDTH-1:0] master_writedata,
    input  logic [DATA_WIDTH-1:0] master_readdata,
    output logic                  busy
);
    import avalon_cmd_pkg::*;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [2:0]              lat_q, lat_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    busy_q, busy_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic                    master_read_q, master_read_d;
    logic                    master_write_q, master_write_d;
    logic [ADDR_WIDTH-1:0]   master_address_q, master_address_d;
    logic [DATA_WIDTH-1:0]   master_writedata_q, master_writedata_d;
    logic                    w_op_bus;

`ifdef AVALON_CMD_MASTER_POLL_EN
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);
    localparam logic [7:0]  GAP_LOAD   = 8'(POLL_GAP - 1);

    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [7:0]              gap_q, gap_d;
    logic [15:0]             attempts_q, attempts_d;
    logic [15:0]             w_attempts_inc;

    assign w_op_bus       = (cmd_op == OP_WRITE) || (cmd_op == OP_READ) || (cmd_op == OP_POLL);
    // Saturating so a huge POLL_MAX can never wrap the count back to zero.
    assign w_attempts_inc = (&attempts_q) ? attempts_q : attempts_q + 16'd1;
`else
    logic unused_poll_cfg;

    assign w_op_bus        = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
    assign unused_poll_cfg = ^{cmd_mask, 16'(POLL_MAX), 8'(POLL_GAP)};
`endif

    always_comb begin
        state_d            = state_q;
        op_d               = op_q;
        addr_d             = addr_q;
        data_d             = data_q;
        lat_d              = lat_q;
        cmd_ready_d        = cmd_ready_q;
        busy_d             = busy_q;
        rsp_valid_d        = rsp_valid_q;
        rsp_data_d         = rsp_data_q;
        rsp_status_d       = rsp_status_q;
        master_read_d      = 1'b0;
        master_write_d     = 1'b0;
        master_address_d   = '0;
        master_writedata_d = '0;
`ifdef AVALON_CMD_MASTER_POLL_EN
        mask_d             = mask_q;
        gap_d              = gap_q;
        attempts_d         = attempts_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    addr_d      = cmd_address;
                    data_d      = cmd_data;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
`ifdef AVALON_CMD_MASTER_POLL_EN
                    mask_d      = cmd_mask;
                    attempts_d  = '0;
`endif
                    if (w_op_bus) begin
                        state_d          = S_STROBE;
                        master_address_d = cmd_address;
                        if (cmd_op == OP_WRITE) begin
                            master_write_d     = 1'b1;
                            master_writedata_d = cmd_data;
                        end else begin
                            master_read_d      = 1'b1;
                        end
                    end else begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_status_d = ST_BADOP;
                    end
                end
            end
            S_STROBE: begin
                if (op_q == OP_WRITE) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_status_d = ST_OK;
                end else begin
                    state_d      = S_RDWAIT;
                    lat_d        = LAT_LOAD;
                end
            end
            S_RDWAIT: begin
                if (lat_q != 3'd0) begin
                    lat_d = lat_q - 3'd1;
                end else begin
`ifdef AVALON_CMD_MASTER_POLL_EN
                    if (op_q == OP_POLL) begin
                        attempts_d = w_attempts_inc;
                        if ((master_readdata & mask_q) == (data_q & mask_q)) begin
                            state_d      = S_RESP;
                            rsp_valid_d  = 1'b1;
                            rsp_data_d   = master_readdata;
                            rsp_status_d = ST_OK;
                        end else if (w_attempts_inc >= POLL_LIMIT) begin
                            state_d      = S_RESP;
                            rsp_valid_d  = 1'b1;
                            rsp_data_d   = master_readdata;
                            rsp_status_d = ST_TIMEOUT;
                        end else if (POLL_GAP == 0) begin
                            state_d          = S_STROBE;
                            master_read_d    = 1'b1;
                            master_address_d = addr_q;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else
`endif
                    begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = master_readdata;
                        rsp_status_d = ST_OK;
                    end
                end
            end
            S_GAP: begin
`ifdef AVALON_CMD_MASTER_POLL_EN
                if (gap_q == 8'd0) begin
                    state_d          = S_STROBE;
                    master_read_d    = 1'b1;
                    master_address_d = addr_q;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
`else
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    rsp_data_d   = '0;
                    rsp_status_d = ST_OK;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            op_q               <= OP_WRITE;
            addr_q             <= '0;
            data_q             <= '0;
            lat_q              <= '0;
            cmd_ready_q        <= 1'b1;
            busy_q             <= 1'b0;
            rsp_valid_q        <= 1'b0;
            rsp_data_q         <= '0;
            rsp_status_q       <= ST_OK;
            master_read_q      <= 1'b0;
            master_write_q     <= 1'b0;
            master_address_q   <= '0;
            master_writedata_q <= '0;
`ifdef AVALON_CMD_MASTER_POLL_EN
            mask_q             <= '0;
            gap_q              <= '0;
            attempts_q         <= '0;
`endif
        end else begin
            state_q            <= state_d;
            op_q               <= op_d;
            addr_q             <= addr_d;
            data_q             <= data_d;
            lat_q              <= lat_d;
            cmd_ready_q        <= cmd_ready_d;
            busy_q             <= busy_d;
            rsp_valid_q        <= rsp_valid_d;
            rsp_data_q         <= rsp_data_d;
            rsp_status_q       <= rsp_status_d;
            master_read_q      <= master_read_d;
            master_write_q     <= master_write_d;
            master_address_q   <= master_address_d;
            master_writedata_q <= master_writedata_d;
`ifdef AVALON_CMD_MASTER_POLL_EN
            mask_q             <= mask_d;
            gap_q              <= gap_d;
            attempts_q         <= attempts_d;
`endif
        end
    end

    // Reset must kill an in-flight strobe or response in the same cycle it is asserted.
    assign master_read      = master_read_q  & ~reset;
    assign master_write     = master_write_q & ~reset;
    assign master_address   = reset ? '0 : master_address_q;
    assign master_writedata = reset ? '0 : master_writedata_q;
    assign rsp_valid        = rsp_valid_q & ~reset;
    assign rsp_data         = rsp_data_q;
    assign rsp_status       = rsp_status_q;
    assign cmd_ready        = cmd_ready_q;
    assign busy             = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_cmd_master
// Description : Directed bench for avalon_cmd_master against a small register
//               slave; POLL vectors are used when AVALON_CMD_MASTER_POLL_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_cmd_master;
    import avalon_cmd_pkg::*;

    localparam int POLL_MAX_TB = 20;
    localparam int POLL_GAP_TB = 4;
    localparam int RD_SPACING  = 1 + 1 + POLL_GAP_TB;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_address;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [5:0]  master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    avalon_cmd_master #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .READ_LATENCY(1),
        .POLL_MAX(POLL_MAX_TB), .POLL_GAP(POLL_GAP_TB)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .master_address(master_address),
        .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_readdata(master_readdata),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register slave, read latency 1; the counter register advances on each read.
    logic [31:0] s_ctrl  = '0;
    logic [31:0] s_count = '0;
    logic [31:0] s_rdata = '0;
    assign master_readdata = s_rdata;

    always @(posedge clk) begin
        if (master_write && master_address == REG_CTRL) s_ctrl <= master_writedata;
        if (master_read) begin
            case (master_address)
                REG_CTRL:    s_rdata <= s_ctrl;
                REG_COUNT:   begin s_rdata <= s_count; s_count <= s_count + 32'd1; end
                REG_VERSION: s_rdata <= SYS_VERSION;
                default:     s_rdata <= '0;
            endcase
        end
    end

    int          rd_cnt = 0, wr_cnt = 0, both_hi = 0, leak = 0, space_bad = 0;
    int          last_rd_cyc = -1, last_wr_cyc = -1, prev_rd = -1;
    logic [5:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always @(negedge clk) begin
        if (master_read && master_write) both_hi = both_hi + 1;
        if (!master_read && !master_write && (master_address != '0 || master_writedata != '0))
            leak = leak + 1;
        if (master_write) begin
            wr_cnt = wr_cnt + 1; last_wr_cyc = cyc;
            last_wr_addr = master_address; last_wr_data = master_writedata;
        end
        if (master_read) begin
            if (prev_rd >= 0 && (cyc - prev_rd) != RD_SPACING) space_bad = space_bad + 1;
            rd_cnt = rd_cnt + 1; last_rd_cyc = cyc; prev_rd = cyc;
            last_rd_addr = master_address;
        end else if (!busy) begin
            prev_rd = -1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a rising edge; returns the acceptance cycle and then scrambles the inputs.
    task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [31:0] d,
                         input logic [31:0] m, output int t);
        t = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_address = a; cmd_data = d; cmd_mask = m;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin t = cyc; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'b11; cmd_address = 6'h3F;
        cmd_data = 32'hA5A5_5A5A; cmd_mask = 32'h0F0F_F0F0;
    endtask

    task automatic wait_rsp(output int rc, output logic [31:0] d, output logic [1:0] s);
        rc = -1; d = '0; s = '0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (rsp_valid) begin rc = cyc; d = rsp_data; s = rsp_status; break; end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    int          t, rc, rc2, h, r0, w0, sb0, n;
    logic [31:0] d;
    logic [1:0]  s;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_address = '0;
        cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes",   32'({master_read, master_write}), 32'd0);
        chk("rst_addr",      32'(master_address), 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        @(posedge clk); #1;

        // WRITE 0x00 <= 3
        w0 = wr_cnt; r0 = rd_cnt;
        issue(OP_WRITE, REG_CTRL, 32'h3, 32'h0, t);
        wait_rsp(rc, d, s);
        chk("wr_strobe_cyc", last_wr_cyc, t + 1);
        chk("wr_strobe_cnt", wr_cnt - w0, 1);
        chk("wr_addr",       32'(last_wr_addr), 32'(REG_CTRL));
        chk("wr_data",       last_wr_data, 32'h3);
        chk("wr_rsp_cyc",    rc, t + 2);
        chk("wr_rsp_data",   d, 32'h0);
        chk("wr_rsp_status", 32'(s), 32'(ST_OK));
        chk("wr_no_read",    rd_cnt - r0, 0);
        consume();

        issue(OP_READ, REG_CTRL, 32'h0, 32'h0, t);
        wait_rsp(rc, d, s);
        chk("rdback_data", d, 32'h3);
        consume();

        // READ SYS_VERSION
        r0 = rd_cnt; w0 = wr_cnt;
        issue(OP_READ, REG_VERSION, 32'h0, 32'h0, t);
        wait_rsp(rc, d, s);
        chk("rd_strobe_cyc", last_rd_cyc, t + 1);
        chk("rd_strobe_cnt", rd_cnt - r0, 1);
        chk("rd_addr",       32'(last_rd_addr), 32'(REG_VERSION));
        chk("rd_rsp_cyc",    rc, t + 3);
        chk("rd_rsp_data",   d, 32'h14);
        chk("rd_rsp_status", 32'(s), 32'(ST_OK));
        chk("rd_no_write",   wr_cnt - w0, 0);
        consume();

        // Backpressure: response held while a second command waits
        issue(OP_READ, REG_VERSION, 32'h0, 32'h0, t);
        wait_rsp(rc, d, s);
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_address = REG_CTRL; cmd_data = 32'h7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data",  rsp_data, 32'h14);
            chk("hold_rsp_stat",  32'(rsp_status), 32'(ST_OK));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        w0 = wr_cnt;
        rsp_ready = 1'b1; h = cyc;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("hold_ready_after", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(rc2, d, s);
        chk("hold_wr_cyc",  last_wr_cyc, h + 2);
        chk("hold_wr_cnt",  wr_cnt - w0, 1);
        chk("hold_wr_data", last_wr_data, 32'h7);
        chk("hold_rsp_cyc", rc2, h + 3);
        consume();

        // Reserved op
        r0 = rd_cnt; w0 = wr_cnt;
        issue(OP_RSVD, REG_CTRL, 32'h1, 32'h0, t);
        wait_rsp(rc, d, s);
        chk("bad_rsp_cyc",    rc, t + 1);
        chk("bad_rsp_status", 32'(s), 32'(ST_BADOP));
        chk("bad_rsp_data",   d, 32'h0);
        chk("bad_no_strobe",  (rd_cnt - r0) + (wr_cnt - w0), 0);
        consume();

        // Reset in the strobe cycle of a READ
        r0 = rd_cnt;
        issue(OP_READ, REG_VERSION, 32'h0, 32'h0, t);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobe", 32'(master_read), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) n = n + 1;
        end
        chk("rst_mid_no_rsp",  n, 0);
        chk("rst_mid_no_read", rd_cnt - r0, 0);
        @(posedge clk); #1;

`ifdef AVALON_CMD_MASTER_POLL_EN
        // POLL the counter for 0x10: reads return 0..16
        r0 = rd_cnt; sb0 = space_bad;
        issue(OP_POLL, REG_COUNT, 32'h10, 32'hFFFF_FFFF, t);
        wait_rsp(rc, d, s);
        chk("poll_status",  32'(s), 32'(ST_OK));
        chk("poll_data",    d, 32'h10);
        chk("poll_reads",   rd_cnt - r0, 17);
        chk("poll_spacing", space_bad - sb0, 0);
        chk("poll_rsp_cyc", rc, t + 1 + 16 * RD_SPACING + 2);
        consume();

        // Masked POLL: counter now 17, bit0 matches on first read
        r0 = rd_cnt;
        issue(OP_POLL, REG_COUNT, 32'h15, 32'h1, t);
        wait_rsp(rc, d, s);
        chk("pmask_status", 32'(s), 32'(ST_OK));
        chk("pmask_data",   d, 32'h11);
        chk("pmask_reads",  rd_cnt - r0, 1);
        consume();

        // POLL timeout on a constant-zero register
        r0 = rd_cnt;
        issue(OP_POLL, REG_ZERO, 32'h1, 32'hFFFF_FFFF, t);
        wait_rsp(rc, d, s);
        chk("ptmo_status",  32'(s), 32'(ST_TIMEOUT));
        chk("ptmo_data",    d, 32'h0);
        chk("ptmo_reads",   rd_cnt - r0, POLL_MAX_TB);
        chk("ptmo_rsp_cyc", rc, t + 1 + (POLL_MAX_TB - 1) * RD_SPACING + 2);
        consume();
`else
        // Without poll support op 10 is rejected like a reserved op
        r0 = rd_cnt; w0 = wr_cnt;
        issue(OP_POLL, REG_COUNT, 32'h10, 32'hFFFF_FFFF, t);
        wait_rsp(rc, d, s);
        chk("nopoll_rsp_cyc",   rc, t + 1);
        chk("nopoll_status",    32'(s), 32'(ST_BADOP));
        chk("nopoll_data",      d, 32'h0);
        chk("nopoll_no_strobe", (rd_cnt - r0) + (wr_cnt - w0), 0);
        consume();
`endif

        chk("never_both_strobes", both_hi, 0);
        chk("addr_data_idle_zero", leak, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
